// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction fetch controller for the 16-bit processor.
// Owns the PC, addresses a combinational instruction memory, buffers fetched
// words in a small prefetch FIFO and hands them to decode over valid/ready.
// A redirect flushes the FIFO and reloads the PC.
// Optional feature macro: FETCH_HALT_ON_ZERO_EN. When it is defined, pushing an
// all-zero word parks the fetcher in HALT until the next redirect.
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
    parameter int                DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_enable,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    output logic [15:0]       fetch_count,
    output logic              halted
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

`ifdef FETCH_HALT_ON_ZERO_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } state_t;
`endif

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   pc_r;
    logic [DATA_W-1:0]   instr_q_r [DEPTH];
    logic [ADDR_W-1:0]   pc_q_r    [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [15:0]         fetch_count_r;
    logic                full_s;
    logic                pop_s;
    logic                push_s;

    // The PC register drives the memory address directly; nothing else is on this path.
    assign imem_addr   = pc_r;
    assign out_valid   = (count_r != {CNT_W{1'b0}});
    assign out_instr   = instr_q_r[rd_ptr_r];
    assign out_pc      = pc_q_r[rd_ptr_r];
    assign fetch_count = fetch_count_r;
`ifdef FETCH_HALT_ON_ZERO_EN
    assign halted      = (state_r == ST_HALT);
`else
    assign halted      = 1'b0;
`endif

    assign full_s = (count_r == CNT_W'(DEPTH));
    assign pop_s  = out_valid && out_ready;

    // Push decision and next-state selection; a redirect overrides everything.
    always_comb begin
        state_nxt_s = state_r;
        push_s      = 1'b0;
        if ((state_r == ST_RUN) && !redirect_valid && (!full_s || pop_s)) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        if (redirect_valid) begin
            state_nxt_s = fetch_enable ? ST_RUN : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fetch_enable) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
`ifdef FETCH_HALT_ON_ZERO_EN
                    if (push_s && (imem_data == {DATA_W{1'b0}})) begin
                        state_nxt_s = ST_HALT;
                    end else if (!fetch_enable) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
`else
                    if (!fetch_enable) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
`endif
                end
`ifdef FETCH_HALT_ON_ZERO_EN
                ST_HALT: begin
                    state_nxt_s = ST_HALT;
                end
`endif
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Fetch state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Program counter: redirect target, else advance on every push (wraps naturally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= RESET_PC;
        end else if (redirect_valid) begin
            pc_r <= redirect_pc;
        end else if (push_s) begin
            pc_r <= pc_r + ADDR_W'(1'b1);
        end else begin
            pc_r <= pc_r;
        end
    end

    // Prefetch FIFO storage, pointers and occupancy; a redirect discards all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_q_r[i] <= {DATA_W{1'b0}};
                pc_q_r[i]    <= {ADDR_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (redirect_valid) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                instr_q_r[wr_ptr_r] <= imem_data;
                pc_q_r[wr_ptr_r]    <= pc_r;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Saturating count of handshakes; a handshake during a redirect still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= 16'h0000;
        end else if (pop_s && (fetch_count_r != 16'hFFFF)) begin
            fetch_count_r <= fetch_count_r + 16'h0001;
        end else begin
            fetch_count_r <= fetch_count_r;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against a
// queue-based reference model of the fetch pipeline.
module tb_fetch_sequencer;

`ifdef FETCH_HALT_ON_ZERO_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_enable;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_instr;
    logic [7:0]  out_pc;
    logic [15:0] fetch_count;
    logic        halted;

    logic [15:0] imem [0:255];
    logic [15:0] prog [0:4];

    // reference model state
    logic [23:0] mq [$];
    logic [7:0]  m_pc;
    logic [15:0] m_fc;
    int          m_mode;   // 0 idle, 1 run, 2 halt

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign imem_data = imem[imem_addr];

    fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_enable   (fetch_enable),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fetch_count    (fetch_count),
        .halted         (halted)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = 8'h00;
        m_fc   = 16'h0000;
        m_mode = 0;
    endtask

    // One clock edge of the fetch pipeline, from the inputs seen before the edge.
    task automatic model_step();
        bit pop;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pop = (mq.size() != 0) && out_ready;
        if (pop) begin
            void'(mq.pop_front());
            if (m_fc != 16'hFFFF) m_fc = m_fc + 16'h0001;
        end
        if (redirect_valid) begin
            mq.delete();
            m_pc   = redirect_pc;
            m_mode = fetch_enable ? 1 : 0;
        end else begin
            if (m_mode == 1 && mq.size() < DEPTH) begin
                mq.push_back({m_pc, imem[m_pc]});
                if (HALT_EN && imem[m_pc] == 16'h0000) m_mode = 2;
                m_pc = m_pc + 8'h01;
            end
            if (m_mode != 2) m_mode = fetch_enable ? 1 : 0;
        end
    endtask

    // Compare every observable output against the model.
    task automatic compare();
        check("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() != 0)});
        check("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
        check("fetch_count", {16'd0, fetch_count}, {16'd0, m_fc});
        check("halted", {31'd0, halted}, {31'd0, (m_mode == 2)});
        if (mq.size() != 0) begin
            check("out_pc", {24'd0, out_pc}, {24'd0, mq[0][23:16]});
            check("out_instr", {16'd0, out_instr}, {16'd0, mq[0][15:0]});
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic redirect_to(input logic [7:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        fetch_enable   = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h00;
        out_ready      = 1'b0;
        for (int i = 0; i < 256; i++) begin
            imem[i] = ($urandom_range(0, 15) == 0) ? 16'h0000 : 16'($urandom);
        end
        prog[0] = 16'h485A; prog[1] = 16'h4A14; prog[2] = 16'h4DF6;
        prog[3] = 16'h4F96; prog[4] = 16'h0880;
        for (int i = 0; i < 5; i++) imem[i] = prog[i];
        imem[5]   = 16'h0000;
        imem[6]   = 16'h1111;
        imem[255] = 16'h1234;
        model_reset();

        #1;
        check("rst_imem_addr", {24'd0, imem_addr}, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'h0);
        check("rst_out_instr", {16'd0, out_instr}, 32'h0);
        check("rst_out_pc", {24'd0, out_pc}, 32'h0);
        check("rst_fetch_count", {16'd0, fetch_count}, 32'h0);
        check("rst_halted", {31'd0, halted}, 32'h0);
        @(negedge clk);
        cycle();
        rst_n = 1'b1;
        cycle();

        // basic streaming
        fetch_enable = 1'b1;
        out_ready    = 1'b1;
        cycle();
        check("t1_first_cycle_invalid", {31'd0, out_valid}, 32'h0);
        cycle();
        for (int k = 0; k < 5; k++) begin
            check("t1_valid", {31'd0, out_valid}, 32'h1);
            check("t1_pc", {24'd0, out_pc}, k);
            check("t1_instr", {16'd0, out_instr}, {16'd0, prog[k]});
            cycle();
        end
        check("t1_fetch_count", {16'd0, fetch_count}, 32'd5);

        // backpressure
        out_ready = 1'b0;
        redirect_to(8'h00);
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (k >= 1) check("t2_hold_instr", {16'd0, out_instr}, 32'h485A);
        end
        check("t2_full_addr", {24'd0, imem_addr}, 32'h02);
        check("t2_head_pc", {24'd0, out_pc}, 32'h00);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("t2_drain_pc", {24'd0, out_pc}, k);
            check("t2_drain_instr", {16'd0, out_instr}, {16'd0, prog[k]});
            cycle();
        end

        // redirect while full
        out_ready = 1'b0;
        redirect_to(8'h00);
        repeat (3) cycle();
        check("t3_full_addr", {24'd0, imem_addr}, 32'h02);
        redirect_to(8'h03);
        check("t3_flushed", {31'd0, out_valid}, 32'h0);
        cycle();
        check("t3_target_pc", {24'd0, out_pc}, 32'h03);
        check("t3_target_instr", {16'd0, out_instr}, 32'h4F96);
        out_ready = 1'b1;
        cycle();
        check("t3_next_pc", {24'd0, out_pc}, 32'h04);
        check("t3_next_instr", {16'd0, out_instr}, 32'h0880);

        // wrap
        redirect_to(8'hFF);
        check("t4_flushed", {31'd0, out_valid}, 32'h0);
        cycle();
        check("t4_pc_ff", {24'd0, out_pc}, 32'hFF);
        check("t4_instr_ff", {16'd0, out_instr}, 32'h1234);
        cycle();
        check("t4_pc_00", {24'd0, out_pc}, 32'h00);
        check("t4_instr_00", {16'd0, out_instr}, 32'h485A);

        // asynchronous reset mid-run
        out_ready = 1'b0;
        redirect_to(8'h00);
        repeat (3) cycle();
        check("t5_queued", {31'd0, out_valid}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", {31'd0, out_valid}, 32'h0);
        check("t5_async_addr", {24'd0, imem_addr}, 32'h00);
        check("t5_async_count", {16'd0, fetch_count}, 32'h0);
        model_reset();
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cycle();
        check("t5_restart_invalid", {31'd0, out_valid}, 32'h0);
        cycle();
        check("t5_restart_pc", {24'd0, out_pc}, 32'h00);
        check("t5_restart_instr", {16'd0, out_instr}, 32'h485A);

        // zero word
        redirect_to(8'h00);
        repeat (6) cycle();
        check("t6_pc5", {24'd0, out_pc}, 32'h05);
        check("t6_instr5", {16'd0, out_instr}, 32'h0000);
`ifdef FETCH_HALT_ON_ZERO_EN
        check("t6_halted", {31'd0, halted}, 32'h1);
        check("t6_addr", {24'd0, imem_addr}, 32'h06);
        repeat (2) cycle();
        check("t6_frozen", {24'd0, imem_addr}, 32'h06);
        check("t6_drained", {31'd0, out_valid}, 32'h0);
        redirect_to(8'h00);
        check("t6_unhalted", {31'd0, halted}, 32'h0);
        cycle();
        check("t6_restart", {16'd0, out_instr}, 32'h485A);
`else
        check("t6_not_halted", {31'd0, halted}, 32'h0);
        cycle();
        check("t6_pc6", {24'd0, out_pc}, 32'h06);
        check("t6_instr6", {16'd0, out_instr}, 32'h1111);
`endif

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            fetch_enable   = ($urandom_range(0, 7) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = 8'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Instruction fetch controller for the 16-bit processor. Owns the program counter and drives the address of the combinational instruction memory (8-bit address, 16-bit word, same-cycle read). Buffers fetched words in a small prefetch FIFO and hands them to decode over a valid/ready handshake. Handles branch/jump redirects with a flush.

Parameters:
ADDR_W, 8, instruction memory address width (PC width)
DATA_W, 16, instruction word width
RESET_PC, 8'h00, PC value loaded on reset
DEPTH, 2, prefetch FIFO entries; power of two, at least 2

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
fetch_enable  in  1  1 = fetch allowed
imem_addr  out  ADDR_W  address to instruction memory; equals PC register
imem_data  in  DATA_W  instruction word at imem_addr, same cycle
redirect_valid  in  1  branch/jump taken
redirect_pc  in  ADDR_W  redirect target
out_valid  out  1  FIFO head holds a valid instruction
out_ready  in  1  decode accepts head
out_instr  out  DATA_W  head instruction word
out_pc  out  ADDR_W  address the head was fetched from
fetch_count  out  16  accepted-instruction counter, saturating
halted  out  1  halt status (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0):
  - PC=RESET_PC; FIFO count=0; FIFO storage cleared.
  - out_valid=0, out_instr=0, out_pc=0, fetch_count=0, halted=0, state IDLE.
  - Reset is effective immediately, mid-operation included; in-flight entries are lost.
- States:
  - IDLE: no fetch. Goes to RUN when fetch_enable=1.
  - RUN: fetch. Goes to IDLE when fetch_enable=0.
  - HALT: only with the optional feature.
  - State is evaluated each cycle; redirect does not change the state except HALT exit.
- imem_addr is combinational from the PC register. No other logic is on the path.
- Push (RUN, no redirect, and FIFO not full or a pop this cycle):
  - FIFO writes {PC, imem_data}.
  - PC <= PC+1, wrapping 8'hFF -> 8'h00.
- Pop: out_valid & out_ready. Head advances; fetch_count increments, holding at 16'hFFFF.
- Simultaneous push and pop on a full FIFO: both happen; count is unchanged.
- out_valid = (count != 0). out_instr and out_pc come from the head entry and are stable while out_valid=1 and out_ready=0.
- Latency: a PC value pushed at edge N is visible at the head in cycle N+1 if the FIFO was empty. Throughput is 1 instruction/cycle with out_ready held at 1.
- Full with no pop: no push; PC holds; imem_addr holds.
- Redirect (highest priority, any state):
  - FIFO flushed (count <= 0).
  - PC <= redirect_pc.
  - No push that cycle.
  - A handshake in the same cycle still counts in fetch_count, but the entry is discarded.
  - The first target instruction is valid 1 cycle after the redirect edge.
- fetch_enable=0: pops continue; redirect still loads PC and flushes.

Optional Feature:
Macro FETCH_HALT_ON_ZERO_EN.
- Defined:
  - A pushed word equal to 16'h0000 is still pushed. The state then goes to HALT and PC still increments.
  - HALT: no pushes; PC and imem_addr frozen; pops continue; halted=1.
  - Exit only by redirect: PC <= redirect_pc, halted=0. Next state is RUN if fetch_enable=1, else IDLE.
  - Reset also clears HALT.
- Not defined:
  - halted tied to 0; HALT state absent.
  - 16'h0000 is fetched like any other word.

Test Plan:
- Memory 00..04 = 485A,4A14,4DF6,4F96,0880; reset release; fetch_enable=1; out_ready=1 -> out_valid in the 2nd cycle after enable. Output is pc 00..04 / 485A,4A14,4DF6,4F96,0880 on consecutive cycles; fetch_count=5 after those.
- Same program, out_ready=0 for 6 cycles -> FIFO holds pc 00,01; imem_addr stays 02; out_instr stays 485A. Then out_ready=1 -> 00,01,02,03 with no gap, duplicate or loss.
- FIFO full (pc 00,01); redirect_valid=1 with redirect_pc=03 -> out_valid=0 the next cycle. The cycle after shows out_pc=03, out_instr=4F96, then 04/0880.
- redirect_pc=FF, mem[FF]=1234, mem[00]=485A -> outputs pc FF/1234 then 00/485A (wrap).
- rst_n driven low asynchronously mid-run with 2 entries queued -> out_valid=0, imem_addr=RESET_PC, fetch_count=0 before the next clk edge. Fetch restarts cleanly from 00.
- mem[05]=0000: with FETCH_HALT_ON_ZERO_EN -> pc 05/0000 delivered, halted=1, imem_addr frozen at 06; redirect to 00 clears halted and restarts at 485A. Without the macro -> fetch continues to pc 06.
